// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and sequencer state type for the sparse MAC row
//
// Purpose: constants shared between the MAC row datapath and its sequencer,
//          plus the sequencer state encoding.
// Ports:   none (package).

package mac_pkg;

    // Row datapath geometry
    localparam int BW      = 4;   // activation / weight width
    localparam int PSUM_BW = 20;  // partial-sum width
    localparam int COL     = 4;   // psums per row
    localparam int NZ      = 2;   // activation lanes selected by a_select

    // Sequencer defaults
    localparam int MAX_STEPS    = 16;
    localparam int CNT_BW       = $clog2(MAX_STEPS) + 1;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRELOAD = 3'd1,
        STREAM  = 3'd2,
        DRAIN   = 3'd3,
        RESULT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mac_seq_counter.sv
// rtl/mac_seq_counter.sv - loadable down-counter with terminal-count flag
//
// Purpose: counts down from a loaded value, stopping at zero; o_tc is high
//          while the count is zero.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-low reset (count -> 0)
//   i_load     in   load i_load_val (has priority over i_dec)
//   i_load_val in   W-bit value to load
//   i_dec      in   decrement by one (held at zero)
//   o_tc       out  terminal count, count == 0

module mac_seq_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/mac_row_seq.sv
// rtl/mac_row_seq.sv - job sequencer for one sparse MAC row
//
// Purpose: accepts a job, preloads the row psums, streams num_steps activation
//          pairs, drains the MAC pipeline, then offers the result on a
//          valid/ready handshake. All outputs are registered.
// Optional: define MAC_ROW_SEQ_STALL_EN to add act_valid; a STREAM cycle whose
//          act_valid is low issues no read and holds the step.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-low reset
//   start_valid  in   job command valid
//   start_ready  out  sequencer idle, can accept a job
//   num_steps    in   activation pairs in job (saturates to max_steps)
//   act_rd_en    out  activation buffer read strobe
//   act_rd_addr  out  activation pair address
//   execute      out  MAC row execute
//   load         out  MAC row psum preload
//   a_select     out  activation lane select (address LSB)
//   psum_valid   out  row result ready
//   psum_ready   in   consumer accepts result
//   busy         out  any non-IDLE state
//   act_valid    in   (MAC_ROW_SEQ_STALL_EN only) activation pair available
//   done         out  one-cycle pulse after the result handshake

module mac_row_seq
    import mac_pkg::*;
#(
    parameter int bw           = BW,
    parameter int psum_bw      = PSUM_BW,
    parameter int col          = COL,
    parameter int max_steps    = MAX_STEPS,
    parameter int cnt_bw       = $clog2(max_steps) + 1,
    parameter int drain_cycles = DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [cnt_bw-1:0] num_steps,
    output logic              act_rd_en,
    output logic [cnt_bw-1:0] act_rd_addr,
    output logic              execute,
    output logic              load,
    output logic              a_select,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic              busy,
`ifdef MAC_ROW_SEQ_STALL_EN
    input  logic              act_valid,
`endif
    output logic              done
);

    // A row geometry the datapath cannot hold never accepts a job.
    localparam bit CFG_OK = (bw > 0) && (psum_bw >= 2 * bw) && (col > 0) &&
                            (max_steps > 0) && (drain_cycles > 0) &&
                            (max_steps < (1 << cnt_bw));

    localparam logic [cnt_bw-1:0] MAX_CNT    = cnt_bw'(max_steps);
    localparam logic [cnt_bw-1:0] DRAIN_LOAD = cnt_bw'(drain_cycles - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [cnt_bw-1:0] r_count;     // saturated step count of the job
    logic [cnt_bw-1:0] r_ptr;       // address of the next read to issue
    logic [cnt_bw-1:0] w_sat;
    logic [cnt_bw-1:0] w_ptr_nxt;
    logic [cnt_bw-1:0] w_step_load_val;

    logic w_start;
    logic w_stream_ok;
    logic w_issue_nxt;
    logic w_drain_load;
    logic w_step_tc;
    logic w_drain_tc;

    logic              r_start_ready;
    logic              r_busy;
    logic              r_execute;
    logic              r_load;
    logic              r_act_rd_en;
    logic [cnt_bw-1:0] r_act_rd_addr;
    logic              r_a_select;
    logic              r_psum_valid;
    logic              r_done;

`ifdef MAC_ROW_SEQ_STALL_EN
    assign w_stream_ok = act_valid;
`else
    assign w_stream_ok = 1'b1;
`endif

    assign w_sat   = (num_steps > MAX_CNT) ? MAX_CNT : num_steps;
    assign w_start = r_start_ready && start_valid && CFG_OK;

    // Step counter holds reads remaining after the current one; its terminal
    // count during an issuing cycle marks the last STREAM step.
    mac_seq_counter #(.W(cnt_bw)) u_step_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start),
        .i_load_val (w_step_load_val),
        .i_dec      (r_act_rd_en),
        .o_tc       (w_step_tc)
    );

    mac_seq_counter #(.W(cnt_bw)) u_drain_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_drain_load),
        .i_load_val (DRAIN_LOAD),
        .i_dec      (r_state == DRAIN),
        .o_tc       (w_drain_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = PRELOAD;
            PRELOAD: w_state_nxt = (r_count != '0) ? STREAM : DRAIN;
            // r_act_rd_en is high exactly in the STREAM cycles that issued a read
            STREAM:  if (r_act_rd_en && w_step_tc) w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_tc) w_state_nxt = RESULT;
            RESULT:  if (psum_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with r_state.
    always_comb begin
        w_issue_nxt     = (w_state_nxt == STREAM) && w_stream_ok;
        w_ptr_nxt       = w_start ? '0 : (r_ptr + cnt_bw'(r_act_rd_en));
        w_step_load_val = (w_sat == '0) ? '0 : (w_sat - cnt_bw'(1));
        w_drain_load    = (w_state_nxt == DRAIN) && (r_state != DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count       <= '0;
            r_ptr         <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_execute     <= 1'b0;
            r_load        <= 1'b0;
            r_act_rd_en   <= 1'b0;
            r_act_rd_addr <= '0;
            r_a_select    <= 1'b0;
            r_psum_valid  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_start) begin
                r_count <= w_sat;
            end
            r_ptr         <= w_ptr_nxt;
            r_start_ready <= (w_state_nxt == IDLE);
            r_busy        <= (w_state_nxt != IDLE);
            r_execute     <= (w_state_nxt == PRELOAD) || (w_state_nxt == DRAIN) || w_issue_nxt;
            r_load        <= (w_state_nxt == PRELOAD);
            r_act_rd_en   <= w_issue_nxt;
            if (w_issue_nxt) begin
                r_act_rd_addr <= w_ptr_nxt;
                r_a_select    <= w_ptr_nxt[0];
            end
            r_psum_valid  <= (w_state_nxt == RESULT);
            r_done        <= (r_state == RESULT) && psum_ready;
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign execute     = r_execute;
    assign load        = r_load;
    assign act_rd_en   = r_act_rd_en;
    assign act_rd_addr = r_act_rd_addr;
    assign a_select    = r_a_select;
    assign psum_valid  = r_psum_valid;
    assign done        = r_done;

endmodule

// File: tb/tb_mac_row_seq.sv
// tb/tb_mac_row_seq.sv - self-checking bench for mac_row_seq

module tb_mac_row_seq;

    localparam int MAXS = 16;
    localparam int DRN  = 3;
    localparam int CW   = 5;

    // expected output vector bits: {start_ready, busy, execute, load, act_rd_en, psum_valid, done}
    localparam logic [6:0] V_IDLE    = 7'b1000000;
    localparam logic [6:0] V_PRELOAD = 7'b0111000;
    localparam logic [6:0] V_ISSUE   = 7'b0110100;
    localparam logic [6:0] V_STALL   = 7'b0100000;
    localparam logic [6:0] V_DRAIN   = 7'b0110000;
    localparam logic [6:0] V_RESULT  = 7'b0100010;
    localparam logic [6:0] V_DONE    = 7'b1000001;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] num_steps;
    logic          act_rd_en;
    logic [CW-1:0] act_rd_addr;
    logic          execute;
    logic          load;
    logic          a_select;
    logic          psum_valid;
    logic          psum_ready;
    logic          busy;
    logic          done;
    logic          act_valid;

    int checks = 0;
    int errors = 0;

    // cycle-indexed reference timeline; cycle 0 is the one after the start handshake
    logic [6:0]    exp_vec   [0:255];
    logic [CW-1:0] exp_addr  [0:255];
    logic          exp_av    [0:255];
    logic          exp_rdy   [0:255];
    logic          is_stream [0:255];
    logic          is_result [0:255];
    int            exp_len;
    int            exp_reads;

    always #5 clk = ~clk;

    mac_row_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .num_steps   (num_steps),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .execute     (execute),
        .load        (load),
        .a_select    (a_select),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .busy        (busy),
`ifdef MAC_ROW_SEQ_STALL_EN
        .act_valid   (act_valid),
`endif
        .done        (done)
    );

    function automatic logic [6:0] out_vec();
        return {start_ready, busy, execute, load, act_rd_en, psum_valid, done};
    endfunction

    // Job timeline: preload, one STREAM cycle per pair (plus stalled cycles),
    // drain, result held rdelay extra cycles, then the done cycle.
    task automatic build_model(input int n, input int rdelay, input logic [31:0] stall_mask);
        int c;
        int k;
        int j;
        for (int i = 0; i < 256; i++) begin
            exp_vec[i]   = V_IDLE;
            exp_addr[i]  = '0;
            exp_av[i]    = 1'b1;
            exp_rdy[i]   = 1'b0;
            is_stream[i] = 1'b0;
            is_result[i] = 1'b0;
        end
        exp_reads = (n > MAXS) ? MAXS : n;
        c = 0;
        exp_vec[0] = V_PRELOAD;
        k = 0;
        j = 0;
        while (k < exp_reads) begin
            c++;
            is_stream[c] = 1'b1;
            if (j < 32 && stall_mask[j]) begin
                exp_vec[c] = V_STALL;
                exp_av[c]  = 1'b0;
            end else begin
                exp_vec[c]  = V_ISSUE;
                exp_addr[c] = CW'(k);
                k++;
            end
            j++;
        end
        for (int d = 0; d < DRN; d++) begin
            c++;
            exp_vec[c] = V_DRAIN;
        end
        for (int r = 0; r <= rdelay; r++) begin
            c++;
            exp_vec[c]   = V_RESULT;
            is_result[c] = 1'b1;
            exp_rdy[c]   = (r == rdelay);
        end
        c++;
        exp_vec[c] = V_DONE;
        exp_len = c;
    endtask

    // Called at a negedge while idle; returns at the negedge of the done cycle.
    task automatic run_job(input int n, input int rdelay, input logic [31:0] stall_mask,
                           input bit hold_start, input string name);
        int reads;
        logic [6:0] got;
        build_model(n, rdelay, stall_mask);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ready before job: got %b want 1", name, start_ready);
        end
        start_valid = 1'b1;
        num_steps   = CW'(n);
        psum_ready  = 1'($urandom);
        act_valid   = 1'($urandom);
        reads = 0;
        for (int c = 0; c <= exp_len; c++) begin
            @(negedge clk);
            got = out_vec();
            checks++;
            if (got !== exp_vec[c]) begin
                errors++;
                $display("FAIL %s cycle %0d outputs: got %b want %b", name, c, got, exp_vec[c]);
            end
            if (exp_vec[c][2]) begin
                reads++;
                checks++;
                if ({a_select, act_rd_addr} !== {exp_addr[c][0], exp_addr[c]}) begin
                    errors++;
                    $display("FAIL %s cycle %0d addr/sel: got %0d/%b want %0d/%b",
                             name, c, act_rd_addr, a_select, exp_addr[c], exp_addr[c][0]);
                end
            end
            start_valid = (c < exp_len) ? (hold_start ? 1'b1 : 1'($urandom)) : 1'b0;
            num_steps   = CW'($urandom);
            psum_ready  = is_result[c] ? exp_rdy[c] : 1'($urandom);
            act_valid   = (c < exp_len && is_stream[c+1]) ? exp_av[c+1] : 1'($urandom);
        end
        checks++;
        if (reads !== exp_reads) begin
            errors++;
            $display("FAIL %s read count: got %0d want %0d", name, reads, exp_reads);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_valid = 1'b1;
        num_steps = CW'(4);
        psum_ready = 1'b1;
        act_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", out_vec(), V_IDLE);
        end
        reset = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vec() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", out_vec(), V_IDLE);
        end
    endtask

    task automatic test_nominal();
        run_job(4, 0, 32'h0, 1'b0, "nominal");
        checks++;
        if ({act_rd_addr, a_select} !== {CW'(3), 1'b1}) begin
            errors++;
            $display("FAIL nominal_addr_hold: got %0d/%b want 3/1", act_rd_addr, a_select);
        end
    endtask

    task automatic test_zero();
        run_job(0, 1, 32'h0, 1'b0, "zero_steps");
    endtask

    task automatic test_backpressure();
        run_job($urandom_range(1, 8), 5, 32'h0, 1'b1, "backpressure");
    endtask

    task automatic test_saturation();
        run_job(20, 0, 32'h0, 1'b0, "saturate_20");
        run_job(16, 0, 32'h0, 1'b0, "max_16");
    endtask

    task automatic test_back_to_back();
        run_job(2, 0, 32'h0, 1'b0, "b2b_first");
        run_job(1, 0, 32'h0, 1'b0, "b2b_second");
        run_job(3, 2, 32'h0, 1'b0, "b2b_third");
    endtask

    task automatic test_random();
        logic [31:0] mask;
        for (int t = 0; t < 8; t++) begin
`ifdef MAC_ROW_SEQ_STALL_EN
            mask = $urandom & 32'h0000_0fff;
`else
            mask = 32'h0;
`endif
            run_job($urandom_range(0, 24), $urandom_range(0, 3), mask, 1'b0, "random");
        end
    endtask

`ifdef MAC_ROW_SEQ_STALL_EN
    task automatic test_stall();
        run_job(3, 0, 32'b110, 1'b0, "stall");
    endtask
`endif

    task automatic test_reset_mid();
        act_valid = 1'b1;
        psum_ready = 1'b0;
        start_valid = 1'b1;
        num_steps = CW'(5);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({act_rd_en, act_rd_addr} !== {1'b1, CW'(2)}) begin
            errors++;
            $display("FAIL reset_mid_step2: got rd_en %b addr %0d want 1/2", act_rd_en, act_rd_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vec() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_mid_idle: got %b want %b", out_vec(), V_IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_mid_after: got %b want %b", out_vec(), V_IDLE);
        end
        run_job(3, 1, 32'h0, 1'b0, "after_reset");
    endtask

    initial begin
        reset = 1'b0;
        start_valid = 1'b0;
        num_steps = '0;
        psum_ready = 1'b0;
        act_valid = 1'b1;
        test_reset();
        test_nominal();
        test_zero();
        test_backpressure();
        test_saturation();
        test_back_to_back();
`ifdef MAC_ROW_SEQ_STALL_EN
        test_stall();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
